// File: rtl/flght_pkg.sv
// flght_pkg: shared types and defaults for the flight motor mixer
package flght_pkg;
  localparam int unsigned MIN_RUN_SPEED_DEF = 200;
  localparam logic [10:0] CAL_SPEED_DEF = 11'h290;
  typedef enum logic [1:0] {IDLE, CALC, LOAD} state_e;
  typedef enum logic [1:0] {M_FRNT, M_BCK, M_LFT, M_RGHT} mtr_e;
  typedef logic signed [13:0] sum_t;
  function automatic sum_t sx10(input logic [9:0] v);
    return {{4{v[9]}}, v};
  endfunction
  function automatic sum_t sx12(input logic [11:0] v);
    return {{2{v[11]}}, v};
  endfunction
endpackage

// File: rtl/mtr_sat.sv
// mtr_sat: clamp a signed 14-bit motor sum into the 0..2047 speed range
module mtr_sat
  import flght_pkg::*;
(
  input  sum_t        sum_i,
  output logic [10:0] spd_o
);
  always_comb spd_o = sum_i[13] ? 11'd0 : (sum_i > sum_t'(2047)) ? 11'h7ff : sum_i[10:0];
endmodule

// File: rtl/flght_mix.sv
// flght_mix: sequential quad-rotor mixer, one motor per cycle through a shared saturator
module flght_mix
  import flght_pkg::*;
#(
  parameter int unsigned MIN_RUN_SPEED = MIN_RUN_SPEED_DEF,
  parameter logic [10:0] CAL_SPEED     = CAL_SPEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [9:0]  ptch_pterm,
  input  logic [9:0]  roll_pterm,
  input  logic [9:0]  yaw_pterm,
  input  logic [11:0] ptch_dterm,
  input  logic [11:0] roll_dterm,
  input  logic [11:0] yaw_dterm,
  input  logic [8:0]  thrst,
  input  logic        inertial_cal,
  output logic [10:0] frnt_spd,
  output logic [10:0] bck_spd,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd,
  output logic        spd_vld,
  output logic        busy,
  output logic        ovr
);
  state_e      state_q, state_d;
  mtr_e        idx_q;
  logic [9:0]  pp_q, rp_q, yp_q;
  logic [11:0] pd_q, rd_q, yd_q;
  logic [8:0]  th_q;
  logic        cal_q, spd_vld_q, ovr_q;
  logic [10:0] stg_q [4];
  logic [10:0] frnt_q, bck_q, lft_q, rght_q;
  logic [10:0] sat_spd, stg_d;
  sum_t        base, tp, tr, ty, sum_d;
  logic        cap;
  always_comb begin
    state_d = state_q == IDLE ? (vld ? CALC : IDLE) :
              state_q == CALC ? (idx_q == M_RGHT ? LOAD : CALC) : IDLE;
    cap     = state_q == IDLE && vld;
  end
  always_comb begin
    base  = sum_t'(MIN_RUN_SPEED) + sum_t'({5'd0, th_q});
    tp    = sx10(pp_q) + sx12(pd_q);
    tr    = sx10(rp_q) + sx12(rd_q);
    ty    = sx10(yp_q) + sx12(yd_q);
    sum_d = idx_q == M_FRNT ? base + tp - ty :
            idx_q == M_BCK  ? base - tp - ty :
            idx_q == M_LFT  ? base + tr + ty : base - tr + ty;
    stg_d = cal_q ? CAL_SPEED : sat_spd;
  end
  mtr_sat u_sat (.sum_i(sum_d), .spd_o(sat_spd));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= M_FRNT;
      {pp_q, rp_q, yp_q} <= '0;
      {pd_q, rd_q, yd_q} <= '0;
      th_q      <= '0;
      cal_q     <= 1'b0;
      stg_q     <= '{default: '0};
      {frnt_q, bck_q, lft_q, rght_q} <= '0;
      spd_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      spd_vld_q <= state_q == LOAD;
      ovr_q     <= vld && busy;
      if (cap) begin
        {pp_q, rp_q, yp_q} <= {ptch_pterm, roll_pterm, yaw_pterm};
        {pd_q, rd_q, yd_q} <= {ptch_dterm, roll_dterm, yaw_dterm};
        th_q  <= thrst;
        cal_q <= inertial_cal;
        idx_q <= M_FRNT;
      end
      if (state_q == CALC) begin
        stg_q[idx_q] <= stg_d;
        idx_q        <= mtr_e'(idx_q + 2'd1);
      end
      if (state_q == LOAD) begin
        frnt_q <= stg_q[M_FRNT];
        bck_q  <= stg_q[M_BCK];
        lft_q  <= stg_q[M_LFT];
        rght_q <= stg_q[M_RGHT];
      end
    end
  end
  assign busy     = state_q != IDLE;
  assign spd_vld  = spd_vld_q;
  assign ovr      = ovr_q;
  assign frnt_spd = frnt_q;
  assign bck_spd  = bck_q;
  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
endmodule

// File: tb/tb_flght_mix.sv
// tb_flght_mix: directed vector bench for the flight motor mixer
module tb_flght_mix;
  logic clk = 1'b0, rst, vld, inertial_cal;
  logic [9:0] pp, rp, yp;
  logic [11:0] pd, rd, yd;
  logic [8:0] th;
  logic [10:0] fs, bs, ls, rs;
  logic spd_vld, busy, ovr;
  int errs = 0, checks = 0;
  typedef struct {
    logic [9:0] pp, rp, yp;
    logic [11:0] pd, rd, yd;
    logic [8:0] th;
    logic cal;
    int ef, eb, el, er;
  } vec_t;
  vec_t tv [9];
  always #5 clk = ~clk;
  flght_mix dut (
    .clk(clk), .rst(rst), .vld(vld),
    .ptch_pterm(pp), .roll_pterm(rp), .yaw_pterm(yp),
    .ptch_dterm(pd), .roll_dterm(rd), .yaw_dterm(yd),
    .thrst(th), .inertial_cal(inertial_cal),
    .frnt_spd(fs), .bck_spd(bs), .lft_spd(ls), .rght_spd(rs),
    .spd_vld(spd_vld), .busy(busy), .ovr(ovr)
  );
  function automatic vec_t mk(int a, int b, int c, int d, int e, int f, int t, int cal,
                              int ef, int eb, int el, int er);
    vec_t v;
    v.pp = 10'(a); v.rp = 10'(b); v.yp = 10'(c);
    v.pd = 12'(d); v.rd = 12'(e); v.yd = 12'(f);
    v.th = 9'(t); v.cal = 1'(cal);
    v.ef = ef; v.eb = eb; v.el = el; v.er = er;
    return v;
  endfunction
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic drive(input vec_t v);
    pp = v.pp; rp = v.rp; yp = v.yp;
    pd = v.pd; rd = v.rd; yd = v.yd;
    th = v.th; inertial_cal = v.cal;
  endtask
  task automatic scramble();
    pp = 10'($urandom); rp = 10'($urandom); yp = 10'($urandom);
    pd = 12'($urandom); rd = 12'($urandom); yd = 12'($urandom);
    th = 9'($urandom); inertial_cal = 1'($urandom);
  endtask
  task automatic chk_spd(input string n, input vec_t v);
    chk({n, ".frnt"}, int'(fs), v.ef);
    chk({n, ".bck"}, int'(bs), v.eb);
    chk({n, ".lft"}, int'(ls), v.el);
    chk({n, ".rght"}, int'(rs), v.er);
  endtask
  task automatic start_wait(input vec_t v, input string n);
    int lat, bcnt;
    drive(v);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    scramble();
    lat = 1;
    bcnt = int'(busy);
    while (!spd_vld && lat < 12) begin
      @(negedge clk);
      lat++;
      bcnt += int'(busy);
    end
    chk({n, ".latency"}, lat, 6);
    chk({n, ".busy_cycles"}, bcnt, 5);
    chk_spd(n, v);
  endtask
  task automatic run(input vec_t v, input string n);
    start_wait(v, n);
    @(negedge clk);
    chk({n, ".pulse_width"}, int'(spd_vld), 0);
  endtask
  initial begin
    int cnt;
    tv[0] = mk(0, 0, 0, 0, 0, 0, 100, 0, 300, 300, 300, 300);
    tv[1] = mk(50, 0, 0, 0, 0, 0, 0, 0, 250, 150, 200, 200);
    tv[2] = mk(0, 0, 0, 0, 0, -2048, 0, 0, 2047, 2047, 0, 0);
    tv[3] = mk(0, 0, 0, 0, 1000, 0, 0, 1, 656, 656, 656, 656);
    tv[4] = mk(-100, 20, 10, 30, -5, 5, 300, 0, 415, 555, 530, 500);
    tv[5] = mk(511, 0, 0, 825, 0, 0, 511, 0, 2047, 0, 711, 711);
    tv[6] = mk(511, 0, 0, 826, 0, 0, 511, 0, 2047, 0, 711, 711);
    tv[7] = mk(-200, 0, 0, -512, 0, 0, 511, 0, 0, 1423, 711, 711);
    tv[8] = mk(511, 0, -512, 2047, 0, -2048, 511, 0, 2047, 713, 0, 0);
    rst = 1'b1; vld = 1'b0;
    drive(tv[0]);
    repeat (2) @(negedge clk);
    chk("reset.frnt", int'(fs), 0);
    chk("reset.bck", int'(bs), 0);
    chk("reset.lft", int'(ls), 0);
    chk("reset.rght", int'(rs), 0);
    chk("reset.spd_vld", int'(spd_vld), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.ovr", int'(ovr), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) run(tv[i], $sformatf("vec%0d", i));
    start_wait(tv[4], "b2b_first");
    run(tv[1], "b2b_second");
    drive(tv[0]);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    drive(tv[5]);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    scramble();
    chk("ovr.pulse", int'(ovr), 1);
    cnt = 0;
    for (int k = 0; k < 12 && !spd_vld; k++) begin
      @(negedge clk);
      cnt += int'(ovr);
    end
    chk("ovr.reached_spd_vld", int'(spd_vld), 1);
    chk("ovr.extra_pulses", cnt, 0);
    chk_spd("ovr", tv[0]);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(spd_vld);
    end
    chk("ovr.no_second_result", cnt, 0);
    drive(tv[4]);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    vld = 1'b1;
    @(negedge clk);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.spd_vld", int'(spd_vld), 0);
    chk("midrst.ovr", int'(ovr), 0);
    chk("midrst.frnt", int'(fs), 0);
    chk("midrst.bck", int'(bs), 0);
    chk("midrst.lft", int'(ls), 0);
    chk("midrst.rght", int'(rs), 0);
    rst = 1'b0;
    vld = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(spd_vld) + int'(busy);
    end
    chk("midrst.no_activity", cnt, 0);
    run(tv[2], "after_rst");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
